// File: rtl/kinase_valve_sequencer_if.sv
// Host-side command/status bundle and chip control-pad outputs of the kinase valve sequencer.
interface kinase_valve_sequencer_if;
  logic        start;
  logic [1:0]  in_sel;
  logic [1:0]  out_sel;
  logic        abort;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  state;
  logic [12:0] pad_ctrl_a;
  logic [3:0]  pad_ctrl_s;
  logic [2:0]  pad_pump_a;
  logic [1:0]  pad_pump_b;

  modport master (
    output start, in_sel, out_sel, abort,
    input  busy, done, err, state, pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b
  );

  modport slave (
    input  start, in_sel, out_sel, abort,
    output busy, done, err, state, pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b
  );
endinterface

// File: rtl/kinase_valve_sequencer.sv
// Fill/mix/incubate/drain valve sequencer for the kinase-activity chip (1 = closed, 0 = open).
// Optional PURGE stage after DRAIN is built when KINASE_SEQ_PURGE_EN is defined.
//
// state | meaning
// IDLE  | all closed, waiting for start
// FILL  | inlet[in_sel] + ring[0] open, pump_a strokes
// MIX   | ring + sieves open, pump_b strokes
// INCUB | all closed, timed wait
// DRAIN | ring[3] + outlet[out_sel] open, pump_a strokes
// DONE  | all closed, one-cycle done pulse
// SAFE  | all closed after abort, then IDLE
// PURGE | waste + ring open, pump_a strokes
module kinase_valve_sequencer #(
  parameter int PHASE_TICKS   = 4,
  parameter int FILL_STROKES  = 8,
  parameter int MIX_STROKES   = 16,
  parameter int INCUB_TICKS   = 64,
  parameter int DRAIN_STROKES = 8,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  kinase_valve_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_MIX   = 3'd2,
    S_INCUB = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5,
    S_SAFE  = 3'd6,
    S_PURGE = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] PT_LAST = CNT_W'(PHASE_TICKS - 1);
  localparam logic [CNT_W-1:0] FS_LAST = CNT_W'(FILL_STROKES - 1);
  localparam logic [CNT_W-1:0] MS_LAST = CNT_W'(MIX_STROKES - 1);
  localparam logic [CNT_W-1:0] IT_LAST = CNT_W'(INCUB_TICKS - 1);
  localparam logic [CNT_W-1:0] DS_LAST = CNT_W'(DRAIN_STROKES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  tick_q, stroke_q, stroke_lim;
  logic [2:0]        phase_q;
  logic [1:0]        in_q, out_q;
  logic              err_q;
  logic              accept, reject, tick_last, phase_last, stroke_end, incub_end;

  assign accept = (state_q == S_IDLE) && bus.start && (bus.in_sel != 2'd3);
  assign reject = (state_q == S_IDLE) && bus.start && (bus.in_sel == 2'd3);

  always_comb begin
    stroke_lim = '0;
    case (state_q)
      S_FILL:  stroke_lim = FS_LAST;
      S_MIX:   stroke_lim = MS_LAST;
      S_DRAIN: stroke_lim = DS_LAST;
      S_PURGE: stroke_lim = FS_LAST;
      default: stroke_lim = '0;
    endcase
  end

  // pump_b strokes are two phases long, pump_a strokes six
  assign tick_last  = (tick_q == PT_LAST);
  assign phase_last = (phase_q == ((state_q == S_MIX) ? 3'd1 : 3'd5));
  assign stroke_end = tick_last && phase_last && (stroke_q == stroke_lim);
  assign incub_end  = (tick_q == IT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_FILL;
      S_FILL:  if (stroke_end) state_d = S_MIX;
      S_MIX:   if (stroke_end) state_d = S_INCUB;
      S_INCUB: if (incub_end) state_d = S_DRAIN;
`ifdef KINASE_SEQ_PURGE_EN
      S_DRAIN: if (stroke_end) state_d = S_PURGE;
      S_PURGE: if (stroke_end) state_d = S_DONE;
`else
      S_DRAIN: if (stroke_end) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      S_SAFE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.abort && (state_q inside {S_FILL, S_MIX, S_INCUB, S_DRAIN, S_PURGE}))
      state_d = S_SAFE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      phase_q  <= '0;
      stroke_q <= '0;
      in_q     <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // every state entry restarts the pump pattern from phase 0
      if ((state_d != state_q) || (state_q inside {S_IDLE, S_DONE, S_SAFE})) begin
        tick_q   <= '0;
        phase_q  <= '0;
        stroke_q <= '0;
      end else if (state_q == S_INCUB) begin
        tick_q <= tick_q + 1'b1;
      end else if (tick_last) begin
        tick_q <= '0;
        if (phase_last) begin
          phase_q  <= '0;
          stroke_q <= stroke_q + 1'b1;
        end else begin
          phase_q <= phase_q + 3'd1;
        end
      end else begin
        tick_q <= tick_q + 1'b1;
      end

      if (accept) begin
        in_q  <= bus.in_sel;
        out_q <= bus.out_sel;
        err_q <= 1'b0;
      end else begin
        if (reject) err_q <= 1'b1;
        if (state_q inside {S_IDLE, S_SAFE}) begin
          in_q  <= '0;
          out_q <= '0;
        end
      end
    end
  end

  logic [12:0] ctrl_a;
  logic [3:0]  ctrl_s;
  logic [2:0]  pump_a, pat_a;
  logic [1:0]  pump_b;

  always_comb begin
    case (phase_q)
      3'd0:    pat_a = 3'b011;
      3'd1:    pat_a = 3'b001;
      3'd2:    pat_a = 3'b101;
      3'd3:    pat_a = 3'b100;
      3'd4:    pat_a = 3'b110;
      3'd5:    pat_a = 3'b010;
      default: pat_a = 3'b111;
    endcase
  end

  always_comb begin
    ctrl_a = 13'h1FFF;
    ctrl_s = 4'hF;
    pump_a = 3'b111;
    pump_b = 2'b11;
    case (state_q)
      S_FILL: begin
        ctrl_a[{2'b00, in_q}] = 1'b0;
        ctrl_a[7]             = 1'b0;
        pump_a                = pat_a;
      end
      S_MIX: begin
        ctrl_a[10:7] = 4'h0;
        ctrl_s       = 4'h0;
        pump_b       = phase_q[0] ? 2'b01 : 2'b10;
      end
      S_DRAIN: begin
        ctrl_a[10]                   = 1'b0;
        ctrl_a[4'd3 + {2'b00, out_q}] = 1'b0;
        pump_a                       = pat_a;
      end
`ifdef KINASE_SEQ_PURGE_EN
      S_PURGE: begin
        ctrl_a[12:7] = 6'h00;
        pump_a       = pat_a;
      end
`endif
      default: ;
    endcase
  end

  assign bus.pad_ctrl_a = ctrl_a;
  assign bus.pad_ctrl_s = ctrl_s;
  assign bus.pad_pump_a = pump_a;
  assign bus.pad_pump_b = pump_b;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = err_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Scoreboard bench for kinase_valve_sequencer: stimulus queues per-cycle expected pad/status
// values, a negedge monitor pops and compares them. Expects KINASE_SEQ_PURGE_EN as the DUT build.
module tb_kinase_valve_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kinase_valve_sequencer_if bus ();

  kinase_valve_sequencer #(
    .PHASE_TICKS(1), .FILL_STROKES(2), .MIX_STROKES(2),
    .INCUB_TICKS(5), .DRAIN_STROKES(2), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef KINASE_SEQ_PURGE_EN
  localparam int DONE_K = 46;
`else
  localparam int DONE_K = 34;
`endif

  typedef struct {
    int          cyc;
    logic [2:0]  st;
    logic        busy;
    logic        done;
    logic        err;
    logic [12:0] ca;
    logic [3:0]  cs;
    logic [2:0]  pa;
    logic [1:0]  pb;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  // pump_a phases as {bit2,bit1,bit0}; the phase list 110,100,101,001,011,010 reads bit0 first
  logic [2:0] pat [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};

  function automatic exp_t closed(input logic [2:0] st, input logic err);
    exp_t r;
    r.cyc = 0; r.st = st; r.busy = (st != 3'd0); r.done = (st == 3'd5); r.err = err;
    r.ca = 13'h1FFF; r.cs = 4'hF; r.pa = 3'b111; r.pb = 2'b11; r.tag = "";
    return r;
  endfunction

  // Expected outputs k clocks after the cycle in which an accepted start was driven
  function automatic exp_t exp_at(input int k, input int in_s, input int out_s, input logic err);
    exp_t r;
    int   idx;
    int   o;
    r   = closed(3'd0, err);
    o   = 3 + out_s;
    if (k >= 1 && k <= 12) begin
      idx = (k - 1) % 6;
      r = closed(3'd1, err);
      r.ca[in_s[3:0]] = 1'b0; r.ca[7] = 1'b0; r.pa = pat[idx[2:0]];
    end else if (k >= 13 && k <= 16) begin
      r = closed(3'd2, err);
      r.ca[10:7] = 4'h0; r.cs = 4'h0;
      r.pb = (((k - 13) % 2) == 0) ? 2'b10 : 2'b01;
    end else if (k >= 17 && k <= 21) begin
      r = closed(3'd3, err);
    end else if (k >= 22 && k <= 33) begin
      idx = (k - 22) % 6;
      r = closed(3'd4, err);
      r.ca[10] = 1'b0; r.ca[o[3:0]] = 1'b0; r.pa = pat[idx[2:0]];
`ifdef KINASE_SEQ_PURGE_EN
    end else if (k >= 34 && k <= 45) begin
      idx = (k - 34) % 6;
      r = closed(3'd7, err);
      r.ca[12:7] = 6'h00; r.pa = pat[idx[2:0]];
`endif
    end else if (k == DONE_K) begin
      r = closed(3'd5, err);
    end
    return r;
  endfunction

  task automatic push(input exp_t r, input int at, input string tag);
    exp_t t;
    t = r; t.cyc = at; t.tag = tag;
    exp_q.push_back(t);
  endtask

  task automatic push_run(input int c0, input int k_lo, input int k_hi,
                          input int in_s, input int out_s, input string tag);
    for (int k = k_lo; k <= k_hi; k++) push(exp_at(k, in_s, out_s, 1'b0), c0 + k, tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cyc ||
          {bus.state, bus.busy, bus.done, bus.err, bus.pad_ctrl_a, bus.pad_ctrl_s, bus.pad_pump_a, bus.pad_pump_b} !==
          {e.st, e.busy, e.done, e.err, e.ca, e.cs, e.pa, e.pb}) begin
        errors++;
        $display("FAIL %s cyc=%0d (exp for %0d): got st=%0d busy=%b done=%b err=%b ca=%h cs=%h pa=%b pb=%b, want st=%0d busy=%b done=%b err=%b ca=%h cs=%h pa=%b pb=%b",
                 e.tag, cyc, e.cyc, bus.state, bus.busy, bus.done, bus.err, bus.pad_ctrl_a,
                 bus.pad_ctrl_s, bus.pad_pump_a, bus.pad_pump_b,
                 e.st, e.busy, e.done, e.err, e.ca, e.cs, e.pa, e.pb);
      end
    end
  end

  initial begin
    int c0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_sel = 2'd0; bus.out_sel = 2'd0;

    for (int i = 1; i <= 3; i++) push(closed(3'd0, 1'b0), i, "reset");
    repeat (3) tick();
    rst = 1'b0;
    push(closed(3'd0, 1'b0), cyc + 1, "idle_after_reset");
    tick();

    // full run; selects changed after acceptance must not matter
    c0 = cyc;
    bus.start = 1'b1; bus.in_sel = 2'd1; bus.out_sel = 2'd2;
    push_run(c0, 1, DONE_K + 1, 1, 2, "full_run");
    tick();
    bus.start = 1'b0; bus.in_sel = 2'd0; bus.out_sel = 2'd0;
    repeat (DONE_K) tick();

    // illegal inlet sets err, stays IDLE
    c0 = cyc;
    bus.start = 1'b1; bus.in_sel = 2'd3;
    push(closed(3'd0, 1'b1), c0 + 1, "illegal_inlet");
    push(closed(3'd0, 1'b1), c0 + 2, "err_sticky");
    tick();
    bus.start = 1'b0;
    tick();

    // legal start clears err, then abort in MIX
    c0 = cyc;
    bus.start = 1'b1; bus.in_sel = 2'd0; bus.out_sel = 2'd0;
    push_run(c0, 1, 13, 0, 0, "run_before_abort");
    push(closed(3'd6, 1'b0), c0 + 14, "abort_safe");
    push(closed(3'd0, 1'b0), c0 + 15, "abort_idle");
    push(closed(3'd0, 1'b0), c0 + 16, "abort_no_done");
    tick();
    bus.start = 1'b0;
    repeat (12) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    repeat (2) tick();

    // abort in IDLE ignored
    c0 = cyc;
    bus.abort = 1'b1;
    push(closed(3'd0, 1'b0), c0 + 1, "abort_in_idle");
    tick();
    bus.abort = 1'b0;

    // start+abort together: start wins; restart during INCUB ignored
    c0 = cyc;
    bus.start = 1'b1; bus.abort = 1'b1; bus.in_sel = 2'd2; bus.out_sel = 2'd3;
    push_run(c0, 1, DONE_K + 1, 2, 3, "start_wins_and_incub_restart");
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    repeat (16) tick();
    bus.start = 1'b1; bus.in_sel = 2'd0; bus.out_sel = 2'd0;
    tick();
    bus.start = 1'b0;
    repeat (DONE_K + 1 - 18) tick();

    // rst clears sticky err
    c0 = cyc;
    bus.start = 1'b1; bus.in_sel = 2'd3;
    push(closed(3'd0, 1'b1), c0 + 1, "err_before_rst");
    push(closed(3'd0, 1'b0), c0 + 2, "rst_clears_err");
    tick();
    bus.start = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;

    // rst mid-DRAIN
    c0 = cyc;
    bus.start = 1'b1; bus.in_sel = 2'd0; bus.out_sel = 2'd1;
    push_run(c0, 1, 24, 0, 1, "run_before_rst");
    push(closed(3'd0, 1'b0), c0 + 25, "rst_mid_drain");
    push(closed(3'd0, 1'b0), c0 + 26, "idle_after_rst");
    tick();
    bus.start = 1'b0;
    repeat (23) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
